// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, registered borrow
// Optional signed-overflow output guarded by SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_d, br_nxt;
    logic [WIDTH-1:0] sr_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        // Full-subtractor bit slice on the current LSBs.
        bit_d   = sa_q[0] ^ sb_q[0] ^ br_q;
        br_nxt  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        sr_nxt  = {bit_d, sr_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                br_d  = br_nxt;
                sr_d  = sr_nxt;
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = sr_nxt;
                    bout_d  = br_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    ovf_d   = (amsb_q != bmsb_q) && (bit_d != amsb_q);
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [W-1:0] diff;
    logic         bout, busy, done;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.d  = av - bv;
        e.bo = (av < bv);
        e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic issue(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit hold);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(model(av, bv));
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk({tag, "_accept_busy"}, busy, 1'b1);
    endtask

    task automatic wait_and_check(input string tag);
        int   k = 0;
        bit   busy_ok = 1'b1;
        exp_t e;
        while (k < 4 * W) begin
            @(negedge clk);
            k++;
            if (!busy) busy_ok = 1'b0;
            if (done) break;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
        chk({tag, "_latency"}, k, W);
        chk({tag, "_busy_held"}, busy_ok, 1'b1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_diff"}, diff, e.d);
            chk({tag, "_bout"}, bout, e.bo);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            chk({tag, "_ovf"}, ovf, e.ov);
`endif
        end
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        chk({tag, "_done_fall"}, done, 1'b0);
        chk({tag, "_busy_fall"}, busy, 1'b0);
    endtask

    initial begin
        bit seen_done;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_diff", diff, 4'b0000);
        chk("reset_bout", bout, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("reset_ovf", ovf, 1'b0);
`endif
        rst = 1'b0;

        issue("op1", 4'b1100, 4'b0100, 1'b0);
        wait_and_check("op1");
        check_idle_after("op1");

        issue("op2", 4'b0010, 4'b1000, 1'b0);
        wait_and_check("op2");
        check_idle_after("op2");

        // start stays high across two operations; second accept only after DONE
        issue("op3", 4'b0000, 4'b0001, 1'b1);
        a = 4'b1001;
        b = 4'b1001;
        exp_q.push_back(model(4'b1001, 4'b1001));
        wait_and_check("op3");
        check_idle_after("op3");
        @(negedge clk);
        chk("op4_accept_busy", busy, 1'b1);
        chk("op4_no_early_done", done, 1'b0);
        wait_and_check("op4");
        start = 1'b0;
        check_idle_after("op4");
        @(negedge clk);
        chk("op4_no_retrigger", busy, 1'b0);

        // operands change right after the accept edge
        issue("op5", 4'b0111, 4'b0011, 1'b0);
        a = 4'b1111;
        b = 4'b1111;
        wait_and_check("op5");
        check_idle_after("op5");

        // reset mid-operation, asserted between clock edges
        issue("op6", 4'b1010, 4'b0011, 1'b0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_diff", diff, 4'b0000);
        chk("async_rst_bout", bout, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abandon_no_done", seen_done, 1'b0);
        chk("abandon_diff_held0", diff, 4'b0000);

        issue("op7", 4'b0101, 4'b0110, 1'b0);
        wait_and_check("op7");
        check_idle_after("op7");

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
